// File: rtl/reorder_buffer_pkg.sv
// Shared core types for the reorder buffer: register-file sizes, buffer depth
// and the per-entry record held in the buffer.
package riscv_pkg;

    localparam int unsigned NUM_A_REGS  = 32;
    localparam int unsigned NUM_P_REGS  = 64;
    localparam int unsigned ROB_ENTRIES = 16;

    localparam int unsigned AR_W = $clog2(NUM_A_REGS);
    localparam int unsigned PR_W = $clog2(NUM_P_REGS);

    typedef struct packed {
        logic            valid;
        logic            done;
        logic            regwrite;
        logic [AR_W-1:0] rd;
        logic [PR_W-1:0] pdest;
        logic [PR_W-1:0] old_pdest;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Rename/execute/retire-side signal bundle of the reorder buffer.
// Suffixes are from the buffer's point of view; master is the pipeline side.
interface reorder_buffer_if #(
    parameter int unsigned NUM_ENTRIES = riscv_pkg::ROB_ENTRIES,
    parameter int unsigned NUM_A_REGS  = riscv_pkg::NUM_A_REGS,
    parameter int unsigned NUM_P_REGS  = riscv_pkg::NUM_P_REGS
);

    localparam int unsigned TAG_W = $clog2(NUM_ENTRIES);
    localparam int unsigned AR_W  = $clog2(NUM_A_REGS);
    localparam int unsigned PR_W  = $clog2(NUM_P_REGS);

    logic             alloc0_valid_i;
    logic             alloc1_valid_i;
    logic             alloc0_regwrite_i;
    logic             alloc1_regwrite_i;
    logic [AR_W-1:0]  alloc0_rd_i;
    logic [AR_W-1:0]  alloc1_rd_i;
    logic [PR_W-1:0]  alloc0_pdest_i;
    logic [PR_W-1:0]  alloc1_pdest_i;
    logic [PR_W-1:0]  alloc0_old_pdest_i;
    logic [PR_W-1:0]  alloc1_old_pdest_i;
    logic [TAG_W-1:0] alloc0_tag_o;
    logic [TAG_W-1:0] alloc1_tag_o;
    logic             full_o;

    logic             cmpl0_valid_i;
    logic             cmpl1_valid_i;
    logic [TAG_W-1:0] cmpl0_tag_i;
    logic [TAG_W-1:0] cmpl1_tag_i;

    logic             commit0_valid_o;
    logic             commit1_valid_o;
    logic [AR_W-1:0]  commit0_rd_o;
    logic [AR_W-1:0]  commit1_rd_o;
    logic [PR_W-1:0]  commit0_pdest_o;
    logic [PR_W-1:0]  commit1_pdest_o;
    logic             free0_en_o;
    logic             free1_en_o;
    logic [PR_W-1:0]  free0_reg_o;
    logic [PR_W-1:0]  free1_reg_o;
    logic             empty_o;

    modport master (
        output alloc0_valid_i, alloc1_valid_i, alloc0_regwrite_i, alloc1_regwrite_i,
               alloc0_rd_i, alloc1_rd_i, alloc0_pdest_i, alloc1_pdest_i,
               alloc0_old_pdest_i, alloc1_old_pdest_i,
               cmpl0_valid_i, cmpl1_valid_i, cmpl0_tag_i, cmpl1_tag_i,
        input  alloc0_tag_o, alloc1_tag_o, full_o,
               commit0_valid_o, commit1_valid_o, commit0_rd_o, commit1_rd_o,
               commit0_pdest_o, commit1_pdest_o,
               free0_en_o, free1_en_o, free0_reg_o, free1_reg_o, empty_o
    );

    modport slave (
        input  alloc0_valid_i, alloc1_valid_i, alloc0_regwrite_i, alloc1_regwrite_i,
               alloc0_rd_i, alloc1_rd_i, alloc0_pdest_i, alloc1_pdest_i,
               alloc0_old_pdest_i, alloc1_old_pdest_i,
               cmpl0_valid_i, cmpl1_valid_i, cmpl0_tag_i, cmpl1_tag_i,
        output alloc0_tag_o, alloc1_tag_o, full_o,
               commit0_valid_o, commit1_valid_o, commit0_rd_o, commit1_rd_o,
               commit0_pdest_o, commit1_pdest_o,
               free0_en_o, free1_en_o, free0_reg_o, free1_reg_o, empty_o
    );

endinterface

// File: rtl/reorder_buffer_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the reorder buffer; full and empty are
// registered from the next occupancy so they reflect the current count.
module rob_ptr_ctrl #(
    parameter int unsigned NUM_ENTRIES = 16,
    parameter int unsigned TAG_W       = $clog2(NUM_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       alloc_cnt,
    input  logic [1:0]       commit_cnt,
    output logic [TAG_W-1:0] head,
    output logic [TAG_W-1:0] tail,
    output logic             full,
    output logic             empty
);

    localparam int unsigned CNT_W = TAG_W + 1;

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    assign count_next = count + CNT_W'(alloc_cnt) - CNT_W'(commit_cnt);

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            head  <= head + TAG_W'(commit_cnt);
            tail  <= tail + TAG_W'(alloc_cnt);
            count <= count_next;
            full  <= count_next > CNT_W'(NUM_ENTRIES - 2);
            empty <= count_next == '0;
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Two-wide in-order retirement buffer: entries allocated in program order,
// marked done by execute, retired up to two per cycle from the head.
module reorder_buffer
    import riscv_pkg::rob_entry_t;
#(
    parameter int unsigned NUM_ENTRIES = riscv_pkg::ROB_ENTRIES,
    parameter int unsigned NUM_A_REGS  = riscv_pkg::NUM_A_REGS,
    parameter int unsigned NUM_P_REGS  = riscv_pkg::NUM_P_REGS
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    reorder_buffer_if.slave rob
);

    localparam int unsigned TAG_W = $clog2(NUM_ENTRIES);
    localparam int unsigned AR_W  = $clog2(NUM_A_REGS);
    localparam int unsigned PR_W  = $clog2(NUM_P_REGS);

    rob_entry_t       entries_q [NUM_ENTRIES];
    rob_entry_t       entries_d [NUM_ENTRIES];
    rob_entry_t       head0;
    rob_entry_t       head1;
    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] head_p1;
    logic [TAG_W-1:0] tail;
    logic [TAG_W-1:0] tail_p1;
    logic             full;
    logic             empty;
    logic             acc0;
    logic             acc1;
    logic             retire0;
    logic             retire1;
    logic [1:0]       n_alloc;
    logic [1:0]       n_commit;

    rob_ptr_ctrl #(
        .NUM_ENTRIES (NUM_ENTRIES)
    ) u_ptr_ctrl (
        .clk        (clk_i),
        .rst_n      (rst_n_i),
        .alloc_cnt  (n_alloc),
        .commit_cnt (n_commit),
        .head       (head),
        .tail       (tail),
        .full       (full),
        .empty      (empty)
    );

    assign tail_p1 = tail + TAG_W'(1);
    assign head_p1 = head + TAG_W'(1);

    // Requests are packed: a lone slot-1 request takes the tail entry.
    assign rob.alloc0_tag_o = tail;
    assign rob.alloc1_tag_o = rob.alloc0_valid_i ? tail_p1 : tail;

    assign acc0    = rob.alloc0_valid_i & ~full;
    assign acc1    = rob.alloc1_valid_i & ~full;
    assign n_alloc = 2'(acc0) + 2'(acc1);

    assign head0    = entries_q[head];
    assign head1    = entries_q[head_p1];
    assign retire0  = head0.valid & head0.done;
    assign retire1  = retire0 & head1.valid & head1.done;
    assign n_commit = 2'(retire0) + 2'(retire1);

    // Completion before retire-clear so a late completion cannot revive a freed slot.
    always_comb begin
        entries_d = entries_q;
        if (rob.cmpl0_valid_i && entries_q[rob.cmpl0_tag_i].valid) begin
            entries_d[rob.cmpl0_tag_i].done = 1'b1;
        end
        if (rob.cmpl1_valid_i && entries_q[rob.cmpl1_tag_i].valid) begin
            entries_d[rob.cmpl1_tag_i].done = 1'b1;
        end
        if (retire0) begin
            entries_d[head].valid = 1'b0;
            entries_d[head].done  = 1'b0;
        end
        if (retire1) begin
            entries_d[head_p1].valid = 1'b0;
            entries_d[head_p1].done  = 1'b0;
        end
        if (acc0) begin
            entries_d[tail].valid     = 1'b1;
            entries_d[tail].done      = 1'b0;
            entries_d[tail].regwrite  = rob.alloc0_regwrite_i;
            entries_d[tail].rd        = rob.alloc0_rd_i;
            entries_d[tail].pdest     = rob.alloc0_pdest_i;
            entries_d[tail].old_pdest = rob.alloc0_old_pdest_i;
        end
        if (acc1) begin
            entries_d[rob.alloc1_tag_o].valid     = 1'b1;
            entries_d[rob.alloc1_tag_o].done      = 1'b0;
            entries_d[rob.alloc1_tag_o].regwrite  = rob.alloc1_regwrite_i;
            entries_d[rob.alloc1_tag_o].rd        = rob.alloc1_rd_i;
            entries_d[rob.alloc1_tag_o].pdest     = rob.alloc1_pdest_i;
            entries_d[rob.alloc1_tag_o].old_pdest = rob.alloc1_old_pdest_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            entries_q <= entries_d;
        end
    end

    // Retire outputs are zeroed when not valid so stale payloads never leak.
    assign rob.commit0_valid_o = retire0;
    assign rob.commit1_valid_o = retire1;
    assign rob.commit0_rd_o    = retire0 ? AR_W'(head0.rd) : '0;
    assign rob.commit1_rd_o    = retire1 ? AR_W'(head1.rd) : '0;
    assign rob.commit0_pdest_o = retire0 ? PR_W'(head0.pdest) : '0;
    assign rob.commit1_pdest_o = retire1 ? PR_W'(head1.pdest) : '0;
    assign rob.free0_en_o      = retire0 & head0.regwrite;
    assign rob.free1_en_o      = retire1 & head1.regwrite;
    assign rob.free0_reg_o     = retire0 ? PR_W'(head0.old_pdest) : '0;
    assign rob.free1_reg_o     = retire1 ? PR_W'(head1.old_pdest) : '0;
    assign rob.full_o          = full;
    assign rob.empty_o         = empty;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic, checked
// against a program-order queue model of in-flight instructions.
module tb_reorder_buffer;

    localparam int N = 16;

    typedef struct {
        int tag;
        int rd;
        int pd;
        int op;
        bit rw;
        bit done;
    } inst_t;

    typedef struct {
        bit v;
        bit rw;
        int rd;
        int pd;
        int op;
    } req_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    reorder_buffer_if rob_if ();

    reorder_buffer dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .rob     (rob_if)
    );

    inst_t q[$];
    int    seq;
    int    n_vec;
    int    n_err;
    req_t  cur_s0;
    req_t  cur_s1;
    bit    cur_cv0;
    bit    cur_cv1;
    int    cur_ct0;
    int    cur_ct1;
    req_t  z;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input req_t s0, input req_t s1, input bit cv0, input int ct0,
                         input bit cv1, input int ct1);
        rob_if.alloc0_valid_i     = s0.v;
        rob_if.alloc0_regwrite_i  = s0.rw;
        rob_if.alloc0_rd_i        = 5'(s0.rd);
        rob_if.alloc0_pdest_i     = 6'(s0.pd);
        rob_if.alloc0_old_pdest_i = 6'(s0.op);
        rob_if.alloc1_valid_i     = s1.v;
        rob_if.alloc1_regwrite_i  = s1.rw;
        rob_if.alloc1_rd_i        = 5'(s1.rd);
        rob_if.alloc1_pdest_i     = 6'(s1.pd);
        rob_if.alloc1_old_pdest_i = 6'(s1.op);
        rob_if.cmpl0_valid_i      = cv0;
        rob_if.cmpl0_tag_i        = 4'(ct0);
        rob_if.cmpl1_valid_i      = cv1;
        rob_if.cmpl1_tag_i        = 4'(ct1);
        cur_s0  = s0;
        cur_s1  = s1;
        cur_cv0 = cv0;
        cur_cv1 = cv1;
        cur_ct0 = ct0;
        cur_ct1 = ct1;
    endtask

    function automatic inst_t mk(input req_t r);
        inst_t e;
        e.tag  = seq % N;
        e.rd   = r.rd;
        e.pd   = r.pd;
        e.op   = r.op;
        e.rw   = r.rw;
        e.done = 1'b0;
        return e;
    endfunction

    // One clock: compare outputs mid-cycle, then advance the model over the edge.
    task automatic step();
        int n;
        bit ef;
        bit e0;
        bit e1;
        @(negedge clk);
        n  = q.size();
        ef = n > N - 2;
        e0 = n > 0 && q[0].done;
        e1 = e0 && n > 1 && q[1].done;
        check("full", rob_if.full_o, ef);
        check("empty", rob_if.empty_o, n == 0);
        check("tag0", rob_if.alloc0_tag_o, seq % N);
        check("tag1", rob_if.alloc1_tag_o, (seq + int'(cur_s0.v)) % N);
        check("commit0_valid", rob_if.commit0_valid_o, e0);
        check("commit1_valid", rob_if.commit1_valid_o, e1);
        if (e0) begin
            check("commit0_rd", rob_if.commit0_rd_o, q[0].rd);
            check("commit0_pdest", rob_if.commit0_pdest_o, q[0].pd);
            check("free0_en", rob_if.free0_en_o, q[0].rw);
            check("free0_reg", rob_if.free0_reg_o, q[0].op);
        end else begin
            check("free0_en_idle", rob_if.free0_en_o, 0);
        end
        if (e1) begin
            check("commit1_rd", rob_if.commit1_rd_o, q[1].rd);
            check("commit1_pdest", rob_if.commit1_pdest_o, q[1].pd);
            check("free1_en", rob_if.free1_en_o, q[1].rw);
            check("free1_reg", rob_if.free1_reg_o, q[1].op);
        end else begin
            check("free1_en_idle", rob_if.free1_en_o, 0);
        end
        if (e0) void'(q.pop_front());
        if (e1) void'(q.pop_front());
        foreach (q[i]) begin
            if ((cur_cv0 && q[i].tag == cur_ct0) || (cur_cv1 && q[i].tag == cur_ct1)) begin
                q[i].done = 1'b1;
            end
        end
        if (!ef) begin
            if (cur_s0.v) begin q.push_back(mk(cur_s0)); seq++; end
            if (cur_s1.v) begin q.push_back(mk(cur_s1)); seq++; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(z, z, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        q.delete();
        seq = 0;
        #1;
        check("rst_empty", rob_if.empty_o, 1);
        check("rst_full", rob_if.full_o, 0);
        check("rst_commit0", rob_if.commit0_valid_o, 0);
        check("rst_commit1", rob_if.commit1_valid_o, 0);
        check("rst_free0_en", rob_if.free0_en_o, 0);
        check("rst_free1_en", rob_if.free1_en_o, 0);
        check("rst_tag0", rob_if.alloc0_tag_o, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic req_t rnd_req(input bit v);
        req_t r;
        r.v  = v;
        r.rw = $urandom_range(0, 3) != 0;
        r.rd = $urandom_range(0, 31);
        r.pd = $urandom_range(0, 63);
        r.op = $urandom_range(0, 63);
        return r;
    endfunction

    task automatic drain();
        for (int k = 0; k < 64 && q.size() > 0; k++) begin
            drive(z, z, 1'b1, q[0].tag, q.size() > 1, q.size() > 1 ? q[1].tag : 0);
            step();
        end
        check("drain_bound", q.size(), 0);
    endtask

    initial begin
        int   prev_tag;
        bit   prev_v;
        bit   cv[2];
        int   ct[2];
        req_t a;
        req_t b;
        n_vec = 0;
        n_err = 0;
        z = '{v: 0, rw: 0, rd: 0, pd: 0, op: 0};

        do_reset();
        rob_if.alloc0_valid_i = 1'b1;
        #1;
        check("rst_tag1", rob_if.alloc1_tag_o, 1);

        // Pair allocation, out-of-order completion, joint retirement.
        a = '{v: 1, rw: 1, rd: 1, pd: 33, op: 1};
        b = '{v: 1, rw: 1, rd: 2, pd: 34, op: 2};
        drive(a, b, 0, 0, 0, 0); step();
        drive(z, z, 1, 1, 0, 0); step();
        drive(z, z, 1, 0, 0, 0); step();
        drive(z, z, 0, 0, 0, 0);
        #1;
        check("pair_free0_reg", rob_if.free0_reg_o, 1);
        check("pair_free1_reg", rob_if.free1_reg_o, 2);
        check("pair_free_en", {rob_if.free0_en_o, rob_if.free1_en_o}, 2'b11);
        step();

        // Store: retires without freeing a register.
        a = '{v: 1, rw: 0, rd: 7, pd: 40, op: 9};
        drive(a, z, 0, 0, 0, 0); step();
        drive(z, z, 1, 2, 0, 0); step();
        drive(z, z, 0, 0, 0, 0);
        #1;
        check("store_commit0", rob_if.commit0_valid_o, 1);
        check("store_free0_en", rob_if.free0_en_o, 0);
        step();

        // Fill to 15, hold a request while full, then retire one at a time.
        for (int i = 0; i < 7; i++) begin
            drive(rnd_req(1), rnd_req(1), 0, 0, 0, 0); step();
        end
        drive(rnd_req(1), z, 0, 0, 0, 0); step();
        drive(z, z, 0, 0, 0, 0);
        #1;
        check("fill_full", rob_if.full_o, 1);
        a = rnd_req(1);
        b = rnd_req(1);
        drive(a, b, 0, 0, 0, 0); step();
        drive(a, b, 1, q[0].tag, 0, 0); step();
        drive(z, z, 1, q[1].tag, 0, 0); step();
        drive(z, z, 0, 0, 0, 0);
        #1;
        check("after_retire_full", rob_if.full_o, 0);
        step();
        drain();

        // Long single-issue run with next-cycle completion across the wrap.
        prev_v = 1'b0;
        prev_tag = 0;
        for (int i = 0; i < 40; i++) begin
            drive(rnd_req(1), z, prev_v, prev_tag, 0, 0);
            prev_tag = seq % N;
            prev_v = 1'b1;
            step();
        end
        drive(z, z, prev_v, prev_tag, 0, 0); step();
        drain();

        // Asynchronous reset with five entries pending and the head retiring.
        drive(rnd_req(1), rnd_req(1), 0, 0, 0, 0); step();
        drive(rnd_req(1), rnd_req(1), 0, 0, 0, 0); step();
        drive(rnd_req(1), z, 0, 0, 0, 0); step();
        drive(z, z, 1, q[0].tag, 0, 0); step();
        check("pre_rst_commit0", rob_if.commit0_valid_o, 1);
        check("pre_rst_empty", rob_if.empty_o, 0);
        do_reset();
        drive(rnd_req(1), z, 0, 0, 0, 0); step();
        drain();

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            a = rnd_req($urandom_range(0, 3) != 0);
            b = rnd_req($urandom_range(0, 2) == 0);
            for (int p = 0; p < 2; p++) begin
                if (q.size() > 0 && $urandom_range(0, 9) < 7) begin
                    cv[p] = 1'b1;
                    ct[p] = q[$urandom_range(0, q.size() - 1)].tag;
                end else begin
                    cv[p] = $urandom_range(0, 1) != 0;
                    ct[p] = $urandom_range(0, N - 1);
                end
            end
            drive(a, b, cv[0], ct[0], cv[1], ct[1]);
            step();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
